crc32: RTL and testbench

//  Byte-serial CRC-32 generator (IEEE 802.3 / Ethernet, reflected), one byte per clock.

---
 rtl/crc32_pkg.sv | 24 ++
 rtl/crc32_byte_step.sv | 13 +
 rtl/crc32.sv | 45 ++++
 tb/tb_crc32.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// CRC-32 (IEEE 802.3, reflected) constants and the single-byte update function.
// Shared by crc32_byte_step and the crc32 top.
package crc32_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOR_OUT   = 32'hFFFFFFFF;
   // Raw state left behind after a message plus its own FCS has been fed through.
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   // Advance the CRC state by one byte, bits consumed LSB first.
   function automatic logic [31:0] crc32_step(input logic [31:0] state,
                                              input logic [7:0]  data);
      logic [31:0] s;
      logic        fb;
      s = state;
      for (int i = 0; i < 8; i++) begin
         fb = s[0] ^ data[i];
         s  = (s >> 1) ^ (fb ? CRC32_POLY_REFL : 32'h0000_0000);
      end
      return s;
   endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Pure combinational one-byte CRC-32 update; thin wrapper around crc32_step.
module crc32_byte_step
   import crc32_pkg::*;
(
   input  logic [31:0] state,
   input  logic [7:0]  data,
   output logic [31:0] next_state
);

   // Eight unrolled shift/XOR iterations of the reflected LFSR.
   assign next_state = crc32_step(state, data);

endmodule

// File: rtl/crc32.sv
// Byte-serial CRC-32 generator (Ethernet FCS), one byte per clock.
// Holds the running state; tx_crc is the state with the output mask applied.
// Optional build macro CRC32_RESIDUE_CHECK_EN adds crc_ok, which flags that the
// bytes fed so far (message followed by its FCS, LSB byte first) check out.
module crc32
   import crc32_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_we,
   input  logic [7:0]  rx_byte,
`ifdef CRC32_RESIDUE_CHECK_EN
   output logic        crc_ok,
`endif
   output logic [31:0] tx_crc
);

   logic [31:0] state;
   logic [31:0] state_next;

   crc32_byte_step u_byte_step (
      .state      (state),
      .data       (rx_byte),
      .next_state (state_next)
   );

   // Running CRC state: reload INIT on reset, advance only on a byte strobe so
   // rx_byte contents are irrelevant while rx_we is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= CRC32_INIT;
      end else if (rx_we) begin
         state <= state_next;
      end
   end

   // Output is a pure function of the register, no path from the inputs.
   assign tx_crc = state ^ CRC32_XOR_OUT;

`ifdef CRC32_RESIDUE_CHECK_EN
   // INIT differs from the residue, so this reads 0 while in reset.
   assign crc_ok = (state == CRC32_RESIDUE);
`endif

endmodule

// File: tb/tb_crc32.sv
// Scoreboard bench for crc32: stimulus pushes expected tx_crc per cycle from a
// whole-message table-driven reference, a negedge monitor pops and compares.
module tb_crc32;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_we;
   logic [7:0]  rx_byte;
   logic [31:0] tx_crc;
`ifdef CRC32_RESIDUE_CHECK_EN
   logic        crc_ok;
`endif

   crc32 dut (
      .clk     (clk),
      .reset   (reset),
      .rx_we   (rx_we),
      .rx_byte (rx_byte),
`ifdef CRC32_RESIDUE_CHECK_EN
      .crc_ok  (crc_ok),
`endif
      .tx_crc  (tx_crc)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [31:0] crc;
      logic        ok;
      string       name;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  msg[$];
   logic [31:0] tbl[256];

   // Reference: standard table-driven CRC-32 over the whole message since reset.
   function automatic logic [31:0] model_crc();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (msg[k]) c = (c >> 8) ^ tbl[(c[7:0] ^ msg[k])];
      return ~c;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic expect_next(input string name);
      exp_t e;
      e.cyc  = cyc + 1;
      e.crc  = model_crc();
      e.ok   = (e.crc == 32'h2144DF1C);
      e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: compare every expectation whose cycle has been reached.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check32({e.name, "_crc"}, tx_crc, e.crc);
`ifdef CRC32_RESIDUE_CHECK_EN
         check1({e.name, "_ok"}, crc_ok, e.ok);
`endif
      end
   end

   // All stimulus tasks start and end just after a falling edge.
   task automatic send(input logic [7:0] b, input string name);
      rx_we   = 1'b1;
      rx_byte = b;
      msg.push_back(b);
      expect_next(name);
      @(negedge clk);
   endtask

   task automatic idle(input string name);
      rx_we   = 1'b0;
      rx_byte = 8'($urandom);
      expect_next(name);
      @(negedge clk);
   endtask

   // Reset lands mid-cycle with a strobe active: reset must win, and take effect at once.
   task automatic do_reset();
      #2;
      rx_we   = 1'b1;
      rx_byte = 8'($urandom);
      reset   = 1'b0;
      msg.delete();
      #1;
      check32("reset_immediate", tx_crc, 32'h0);
      expect_next("reset_hold");
      @(negedge clk);
      expect_next("reset_hold");
      @(negedge clk);
      reset = 1'b1;
      rx_we = 1'b0;
   endtask

   task automatic send_check_str();
      for (int i = 0; i < 9; i++) send(8'(8'h31 + i), "check_str");
   endtask

   initial begin
      for (int n = 0; n < 256; n++) begin
         logic [31:0] c;
         c = n;
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         tbl[n] = c;
      end

      reset   = 1'b0;
      rx_we   = 1'b0;
      rx_byte = 8'h00;

      // 1: reset held, then idle
      repeat (3) begin
         @(negedge clk);
         check32("reset_held", tx_crc, 32'h0);
      end
      reset = 1'b1;
      repeat (4) idle("idle_after_reset");
      check32("idle_zero", tx_crc, 32'h00000000);

      // 2: "123456789" back-to-back
      do_reset();
      send_check_str();
      check32("check_value", tx_crc, 32'hCBF43926);

      // 3: single bytes
      do_reset();
      send(8'h00, "single_00");
      check32("single_00_const", tx_crc, 32'hD202EF8D);
      do_reset();
      send(8'h61, "single_61");
      check32("single_61_const", tx_crc, 32'hE8B7BE43);

      // 4: four zero bytes with gaps of random data on the bus
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(8'h00, "gapped_zero");
         repeat ($urandom_range(1, 3)) idle("gapped_idle");
      end
      check32("gapped_const", tx_crc, 32'h2144DF1C);

      // 5: reset mid-stream, then resend
      do_reset();
      for (int i = 0; i < 4; i++) send(8'(8'h31 + i), "partial");
      do_reset();
      send_check_str();
      check32("restart_value", tx_crc, 32'hCBF43926);

`ifdef CRC32_RESIDUE_CHECK_EN
      // 6: residue check with the correct and a corrupted FCS
      do_reset();
      send_check_str();
      send(8'h26, "fcs"); send(8'h39, "fcs"); send(8'hF4, "fcs"); send(8'hCB, "fcs");
      check1("residue_ok", crc_ok, 1'b1);
      check32("residue_crc", tx_crc, 32'h2144DF1C);
      do_reset();
      send_check_str();
      send(8'h27, "fcs_bad"); send(8'h39, "fcs_bad"); send(8'hF4, "fcs_bad"); send(8'hCB, "fcs_bad");
      check1("residue_bad", crc_ok, 1'b0);
`endif

      // Random messages with random gaps
      for (int m = 0; m < 20; m++) begin
         do_reset();
         repeat ($urandom_range(1, 24)) begin
            if ($urandom_range(0, 3) == 0) idle("rand_idle");
            send(8'($urandom), "rand_byte");
         end
      end

      rx_we = 1'b0;
      for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
